log_to_linear_pipe: RTL and testbench
=====================================

Name: log_to_linear_pipe

Overview:
- Pipelined log-domain to linear-domain converter: the inverse of the existing linear-to-log path.
- Accepts a signed fixed-point base-2 log value (integer exponent plus 8-bit fraction) with sign and zero flags.
- Emits a linear floating-point-style value: exponent, plus a 7-bit mantissa fraction equal to round-to-nearest((2^f - 1) * 128), where f = frac/256.
- Sits between the log-domain MAC/accumulator and linear-domain output/normalisation logic; ready/valid on both sides.

Parameters:
- EXP_WIDTH, 6, width of the signed two's-complement integer part of the log input; passed through as the output exponent.
- TAG_WIDTH, 4, width of an opaque sideband tag carried alongside each transaction.

Ports:
- clock  input  1  single clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept input this cycle.
- in_sign  input  1  sign of the linear value.
- in_zero  input  1  value is exactly zero; log fields are don't-care.
- in_exp  input  EXP_WIDTH  signed integer part of log2|x|.
- in_frac  input  8  fractional part of log2|x|, unsigned, f = in_frac/256.
- in_tag  input  TAG_WIDTH  sideband, returned unchanged.
- out_valid  output  1  output transaction present.
- out_ready  input  1  downstream accepts output.
- out_sign  output  1  copy of in_sign.
- out_zero  output  1  copy of in_zero.
- out_exp  output  EXP_WIDTH  copy of in_exp.
- out_mant  output  7  linear mantissa fraction; value = (1 + out_mant/128) * 2^out_exp.
- out_tag  output  TAG_WIDTH  copy of in_tag.

Behaviour:
- Reset: asynchronous and active-low. While resetn = 0, all stage valid bits and out_valid are 0. out_sign, out_zero, out_exp, out_mant and out_tag are 0. in_ready is 1 from the first cycle after release.
- Datapath: the mantissa is computed as in_frac[7:1] minus a 4-bit correction from an internal 256-entry table indexed by in_frac.
  - The table holds the exact per-entry value needed so that out_mant = round-to-nearest((2^(in_frac/256) - 1) * 128) for all 256 codes.
  - No code is a tie.
  - Maximum correction is 11; out_mant never exceeds 127, so no carry into the exponent.
- When in_zero = 1: out_mant = 0 and out_exp = 0. out_sign and out_tag still pass through.
- Pipeline:
  - Two register stages. S1 registers the inputs plus the table lookup; S2 registers the subtraction result, which drives the outputs.
  - Latency is exactly 2 cycles from an accepted input (in_valid & in_ready) to out_valid, given out_ready held 1.
  - Full throughput: one transaction per cycle sustained.
- Handshake:
  - A transfer occurs on an edge where valid & ready are both 1.
  - S2 loads when it is empty or out_ready = 1.
  - S1 loads when it is empty or S2 is loading.
  - in_ready = !S1_valid | S2_load. in_ready must not depend combinationally on in_valid.
- Stall rules:
  - While out_valid = 1 and out_ready = 0, all out_* signals hold stable.
  - When both stages are full and stalled, in_ready = 0 and no input is lost or duplicated.
  - Order is strictly preserved.
- Bubbles: when in_valid = 0, empty stages propagate; a stage holding valid data is never overwritten unless it is advancing.
- Simultaneous events: on the same edge, S2 may drain while S1 advances into S2 and a new input enters S1.
- Reset mid-operation: in-flight transactions are discarded, and the block is ready again as after power-up.
- out_exp is a pure copy of in_exp; no bias, saturation or overflow handling.

Test Plan:
- Reset then single transfers with out_ready=1 -> each out_valid exactly 2 cycles after acceptance, other fields passed through:
  - frac 0x00 -> mant 0x00; frac 0x01 -> 0x00; frac 0x40 -> 24 (0x18);
  - frac 0x80 -> 53 (0x35); frac 0xC0 -> 87 (0x57); frac 0xFF -> 127 (0x7F).
- Exhaustive sweep of in_frac 0..255 back-to-back, out_ready=1 -> 256 outputs in consecutive cycles matching the golden round((2^(k/256)-1)*128) model, tags 0..15 repeating in order.
- Backpressure: stream 10 inputs, hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after S1/S2 fill, outputs stable while stalled, all 10 delivered in order with no duplicates.
- Zero handling: in_zero=1, in_sign=1, exp=-3, frac=0x80, tag=5 -> out_zero=1, out_sign=1, out_exp=0, out_mant=0, out_tag=5.
- Random valid/ready toggling for 10k cycles against a scoreboard -> zero mismatches, zero lost/extra transactions.
- Assert resetn low for 1 cycle with 2 transactions in flight -> out_valid=0 immediately; no stale output after release; in_ready=1 on the next cycle.

Source files
------------

// File: rtl/log_to_linear_pipe_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | log_to_linear_pipe_if                                                   |
// | Ready/valid bus for the log-to-linear converter (input and output side). |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
interface log_to_linear_pipe_if #(
    parameter int EXP_WIDTH = 6,
    parameter int TAG_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_sign;
    logic                 in_zero;
    logic [EXP_WIDTH-1:0] in_exp;
    logic [7:0]           in_frac;
    logic [TAG_WIDTH-1:0] in_tag;

    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic                 out_zero;
    logic [EXP_WIDTH-1:0] out_exp;
    logic [6:0]           out_mant;
    logic [TAG_WIDTH-1:0] out_tag;

    modport master (
        output in_valid, in_sign, in_zero, in_exp, in_frac, in_tag, out_ready,
        input  in_ready, out_valid, out_sign, out_zero, out_exp, out_mant, out_tag
    );

    modport slave (
        input  in_valid, in_sign, in_zero, in_exp, in_frac, in_tag, out_ready,
        output in_ready, out_valid, out_sign, out_zero, out_exp, out_mant, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/log_to_linear_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | log_to_linear_pipe                                                      |
// | Two-stage log2 -> linear converter: mant = round((2^(frac/256)-1)*128).  |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module log_to_linear_pipe #(
    parameter int EXP_WIDTH = 6,
    parameter int TAG_WIDTH = 4
) (
    input  wire                  clock,
    input  wire                  resetn,
    log_to_linear_pipe_if.slave  bus
);

    // Correction table: entry k = (k >> 1) - round((2^(k/256) - 1) * 128).
    // Rounding boundary t+0.5 lies below 2^(k/256)*128 iff k > floor(256*log2((257+2t)/256)),
    // so the exponent of x^256 is found by eight normalised squarings in Q30.
    function automatic logic [1023:0] build_corr_table();
        logic [1023:0]       tbl;
        logic [128:0][8:0]   e_tab;
        logic [63:0]         x;
        int                  e;
        int                  t;
        tbl = '0;
        for (int i = 0; i < 128; i++) begin
            x = 64'(257 + 2 * i) << 22;
            e = 0;
            for (int s = 0; s < 8; s++) begin
                x = (x * x) >> 30;
                e = 2 * e;
                if (x >= 64'h0000_0000_8000_0000) begin
                    x = x >> 1;
                    e = e + 1;
                end
            end
            e_tab[i] = 9'(e);
        end
        e_tab[128] = 9'd511;
        t = 0;
        for (int k = 0; k < 256; k++) begin
            while (int'(e_tab[t]) < k) t = t + 1;
            tbl[4 * k +: 4] = 4'((k >> 1) - t);
        end
        return tbl;
    endfunction

    localparam logic [1023:0] c_corr_table = build_corr_table();

    logic                 r_s1_valid;
    logic                 r_s1_sign;
    logic                 r_s1_zero;
    logic [EXP_WIDTH-1:0] r_s1_exp;
    logic [6:0]           r_s1_frac_hi;
    logic [3:0]           r_s1_corr;
    logic [TAG_WIDTH-1:0] r_s1_tag;

    logic                 r_s2_valid;
    logic                 r_s2_sign;
    logic                 r_s2_zero;
    logic [EXP_WIDTH-1:0] r_s2_exp;
    logic [6:0]           r_s2_mant;
    logic [TAG_WIDTH-1:0] r_s2_tag;

    logic                 w_s1_load;
    logic                 w_s2_load;
    logic [3:0]           w_corr;
    logic [6:0]           w_mant;

    assign w_s2_load = !r_s2_valid || bus.out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign w_corr    = c_corr_table[{bus.in_frac, 2'b00} +: 4];
    assign w_mant    = r_s1_zero ? 7'd0 : (r_s1_frac_hi - {3'd0, r_s1_corr});

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_exp     <= '0;
            r_s1_frac_hi <= '0;
            r_s1_corr    <= '0;
            r_s1_tag     <= '0;
        end else if (w_s1_load) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign    <= bus.in_sign;
                r_s1_zero    <= bus.in_zero;
                r_s1_exp     <= bus.in_exp;
                r_s1_frac_hi <= bus.in_frac[7:1];
                r_s1_corr    <= w_corr;
                r_s1_tag     <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mant  <= '0;
            r_s2_tag   <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_exp  <= r_s1_zero ? '0 : r_s1_exp;
                r_s2_mant <= w_mant;
                r_s2_tag  <= r_s1_tag;
            end
        end
    end

    assign bus.in_ready  = w_s1_load;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_sign  = r_s2_sign;
    assign bus.out_zero  = r_s2_zero;
    assign bus.out_exp   = r_s2_exp;
    assign bus.out_mant  = r_s2_mant;
    assign bus.out_tag   = r_s2_tag;

endmodule
`default_nettype wire

// File: tb/tb_log_to_linear_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_log_to_linear_pipe                                                   |
// | Directed and random ready/valid traffic against a real-arithmetic model. |
// | Revision: 1.0                                                            |
// +------------------------------------------------------------------------+
module tb_log_to_linear_pipe;
    localparam int EXP_WIDTH = 6;
    localparam int TAG_WIDTH = 4;

    logic        clock;
    logic        resetn;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_out = 0;
    logic        in_fire;
    logic        out_fire;
    logic        ready_seen;
    logic        stalled;
    logic [18:0] stall_word;
    logic [18:0] last_out;
    logic [18:0] exp_q [$];

    log_to_linear_pipe_if #(.EXP_WIDTH(EXP_WIDTH), .TAG_WIDTH(TAG_WIDTH)) bus ();

    log_to_linear_pipe #(.EXP_WIDTH(EXP_WIDTH), .TAG_WIDTH(TAG_WIDTH)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int golden_mant(input int k);
        real v;
        v = ($pow(2.0, real'(k) / 256.0) - 1.0) * 128.0;
        return $rtoi($floor(v + 0.5));
    endfunction

    // Packed as {sign, zero, exp[5:0], mant[6:0], tag[3:0]}
    function automatic logic [18:0] model(input logic s, input logic z, input logic [5:0] e,
                                          input logic [7:0] f, input logic [3:0] t);
        if (z) return {s, 1'b1, 6'd0, 7'd0, t};
        return {s, 1'b0, e, 7'(golden_mant(int'(f))), t};
    endfunction

    function automatic logic [18:0] out_word();
        return {bus.out_sign, bus.out_zero, bus.out_exp, bus.out_mant, bus.out_tag};
    endfunction

    task automatic drive(input logic s, input logic z, input logic [5:0] e,
                         input logic [7:0] f, input logic [3:0] t);
        bus.in_sign = s;
        bus.in_zero = z;
        bus.in_exp  = e;
        bus.in_frac = f;
        bus.in_tag  = t;
    endtask

    // Called just after a falling edge with inputs set; observes the coming rising edge.
    task automatic cycle();
        #1;
        in_fire    = bus.in_valid && bus.in_ready;
        out_fire   = bus.out_valid && bus.out_ready;
        ready_seen = bus.in_ready;
        if (stalled)
            check_value("stall_hold", 32'({bus.out_valid, out_word()}), 32'({1'b1, stall_word}));
        if (out_fire) begin
            n_out++;
            last_out = out_word();
            if (exp_q.size() == 0)
                check_value("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
            else
                check_value("out_data", 32'(out_word()), 32'(exp_q.pop_front()));
        end
        if (in_fire)
            exp_q.push_back(model(bus.in_sign, bus.in_zero, bus.in_exp, bus.in_frac, bus.in_tag));
        stalled    = bus.out_valid && !bus.out_ready;
        stall_word = out_word();
        @(negedge clock);
    endtask

    task automatic single(input logic s, input logic z, input logic [5:0] e,
                          input logic [7:0] f, input logic [3:0] t, input string name);
        int lat;
        drive(s, z, e, f, t);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        cycle();
        check_value({name, "_accept"}, 32'(in_fire), 32'd1);
        bus.in_valid = 1'b0;
        lat = 0;
        do begin
            lat++;
            cycle();
        end while (!out_fire && lat < 8);
        check_value({name, "_latency"}, 32'(lat), 32'd2);
    endtask

    logic [7:0] dir_frac [6] = '{8'h00, 8'h01, 8'h40, 8'h80, 8'hC0, 8'hFF};
    int         dir_mant [6] = '{0, 0, 24, 53, 87, 127};

    initial begin
        int base;
        int sent;
        int blocked;
        int misses;
        stalled      = 1'b0;
        stall_word   = '0;
        last_out     = '0;
        resetn       = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 1'b0, 6'd0, 8'd0, 4'd0);

        repeat (3) @(negedge clock);
        check_value("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("rst_out_word", 32'(out_word()), 32'd0);
        resetn = 1'b1;
        #1;
        check_value("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);

        for (int i = 0; i < 6; i++) begin
            single(1'($urandom), 1'b0, 6'($urandom), dir_frac[i], 4'(i + 1), "dir");
            check_value("dir_mant", 32'(last_out[10:4]), 32'(dir_mant[i]));
        end

        single(1'b1, 1'b1, 6'h3D, 8'h80, 4'd5, "zero");
        check_value("zero_word", 32'(last_out), 32'({1'b1, 1'b1, 6'd0, 7'd0, 4'd5}));

        // Back-to-back sweep of every fraction code
        base   = n_out;
        misses = 0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            drive(1'($urandom), 1'b0, 6'($urandom), 8'(k), 4'(k));
            bus.in_valid = 1'b1;
            cycle();
            if (!in_fire) misses++;
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check_value("sweep_accept_misses", 32'(misses), 32'd0);
        check_value("sweep_outputs", 32'(n_out - base), 32'd256);

        // Ten inputs with a five-cycle output stall in the middle
        base    = n_out;
        sent    = 0;
        blocked = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            drive(1'(sent), 1'b0, 6'(sent * 3), 8'(sent * 25 + 7), 4'(sent));
            bus.in_valid  = 1'b1;
            bus.out_ready = !(c >= 4 && c < 9);
            cycle();
            if (!ready_seen) blocked++;
            if (in_fire) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle();
        check_value("bp_sent", 32'(sent), 32'd10);
        check_value("bp_in_ready_dropped", 32'(blocked > 0), 32'd1);
        check_value("bp_outputs", 32'(n_out - base), 32'd10);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom), ($urandom_range(0, 7) == 0), 6'($urandom), 8'($urandom), 4'($urandom));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) cycle();
        check_value("rand_lost", 32'(exp_q.size()), 32'd0);

        // Reset with two transactions in flight
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b0, 6'd7, 8'h33, 4'hA);
        bus.in_valid = 1'b1;
        cycle();
        drive(1'b0, 1'b0, 6'd9, 8'h99, 4'hB);
        cycle();
        bus.in_valid = 1'b0;
        resetn = 1'b0;
        #1;
        check_value("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_value("midrst_out_word", 32'(out_word()), 32'd0);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        #1;
        check_value("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clock);
        base = n_out;
        repeat (4) cycle();
        check_value("midrst_no_stale", 32'(n_out - base), 32'd0);

        single(1'b0, 1'b0, 6'd2, 8'h40, 4'd3, "post_rst");
        check_value("post_rst_mant", 32'(last_out[10:4]), 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
